// File: rtl/map_rom_arbiter_if.sv
// Requester/ROM bundle for map_rom_arbiter.
// master = requesters and ROM side, slave = arbiter.
interface map_rom_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 12
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_rgb;
  logic              disp_valid;
  logic              disp_miss;

  logic              c0_req;
  logic [ADDR_W-1:0] c0_addr;
  logic              c0_gnt;
  logic [DATA_W-1:0] c0_rgb;
  logic              c0_valid;

  logic              c1_req;
  logic [ADDR_W-1:0] c1_addr;
  logic              c1_gnt;
  logic [DATA_W-1:0] c1_rgb;
  logic              c1_valid;

  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_rgb;

  modport slave (
    input  disp_req, disp_addr,
    input  c0_req, c0_addr,
    input  c1_req, c1_addr,
    input  rom_rgb,
    output disp_rgb, disp_valid, disp_miss,
    output c0_gnt, c0_rgb, c0_valid,
    output c1_gnt, c1_rgb, c1_valid,
    output rom_addr
  );

  modport master (
    output disp_req, disp_addr,
    output c0_req, c0_addr,
    output c1_req, c1_addr,
    output rom_rgb,
    input  disp_rgb, disp_valid, disp_miss,
    input  c0_gnt, c0_rgb, c0_valid,
    input  c1_gnt, c1_rgb, c1_valid,
    input  rom_addr
  );
endinterface

// File: rtl/map_rom_arbiter.sv
// Display-priority arbiter with round-robin collision probes on one map ROM port.
// Define MAP_ARB_STARVE_EN to let starved collision probes override display.
module map_rom_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 12,
  parameter int ROM_LAT  = 1,
  parameter int MAX_WAIT = 1023
) (
  input logic              clk,
  input logic              rst,
  map_rom_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    T_NONE,
    T_DISP,
    T_C0,
    T_C1
  } tag_t;

  if (ROM_LAT < 1 || ROM_LAT > 4) begin : g_lat_chk
    $error("ROM_LAT must be 1..4");
  end
  if (MAX_WAIT < 1) begin : g_wait_chk
    $error("MAX_WAIT must be positive");
  end

  logic              c0_gnt_q;
  logic              c1_gnt_q;
  logic              rr_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [ADDR_W-1:0] rom_addr_d;
  tag_t              tag_q [ROM_LAT+1];
  tag_t              tag_out;
  logic [DATA_W-1:0] disp_rgb_q;
  logic [DATA_W-1:0] c0_rgb_q;
  logic [DATA_W-1:0] c1_rgb_q;
  logic              disp_valid_q;
  logic              c0_valid_q;
  logic              c1_valid_q;

  logic              c0_e;
  logic              c1_e;
  logic              s0;
  logic              s1;
  logic              ovr;
  logic              dsel;
  logic              csel;
  tag_t              win;

`ifdef MAP_ARB_STARVE_EN
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [WW-1:0]    w0_q;
  logic [WW-1:0]    w1_q;
  logic [ROM_LAT:0] miss_q;
  logic             disp_miss_q;
`endif

  // A probe is deaf in the cycle its grant pulse is out.
  always_comb begin
    c0_e = bus.c0_req & ~c0_gnt_q;
    c1_e = bus.c1_req & ~c1_gnt_q;
    s0   = 1'b0;
    s1   = 1'b0;
`ifdef MAP_ARB_STARVE_EN
    s0   = c0_e & (w0_q == WW'(MAX_WAIT));
    s1   = c1_e & (w1_q == WW'(MAX_WAIT));
`endif
    ovr  = s0 | s1;
    dsel = ~ovr & bus.disp_req;
    csel = ~ovr & ~bus.disp_req & (c0_e | c1_e);
    win  = T_NONE;
    unique case (1'b1)
      ovr:     win = (s0 & (~s1 | ~rr_q)) ? T_C0 : T_C1;
      dsel:    win = T_DISP;
      csel:    win = (c0_e & (~c1_e | ~rr_q)) ? T_C0 : T_C1;
      default: win = T_NONE;
    endcase
  end

  always_comb begin
    rom_addr_d = rom_addr_q;
    unique case (win)
      T_DISP:  rom_addr_d = bus.disp_addr;
      T_C0:    rom_addr_d = bus.c0_addr;
      T_C1:    rom_addr_d = bus.c1_addr;
      default: rom_addr_d = rom_addr_q;
    endcase
  end

  assign tag_out = tag_q[ROM_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_addr_q   <= '0;
      c0_gnt_q     <= 1'b0;
      c1_gnt_q     <= 1'b0;
      rr_q         <= 1'b0;
      disp_rgb_q   <= '0;
      c0_rgb_q     <= '0;
      c1_rgb_q     <= '0;
      disp_valid_q <= 1'b0;
      c0_valid_q   <= 1'b0;
      c1_valid_q   <= 1'b0;
      for (int i = 0; i <= ROM_LAT; i++) begin
        tag_q[i] <= T_NONE;
      end
    end else begin
      rom_addr_q <= rom_addr_d;
      c0_gnt_q   <= (win == T_C0);
      c1_gnt_q   <= (win == T_C1);
      if (win == T_C0) begin
        rr_q <= 1'b1;
      end else if (win == T_C1) begin
        rr_q <= 1'b0;
      end
      tag_q[0] <= win;
      for (int i = 1; i <= ROM_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      disp_valid_q <= (tag_out == T_DISP);
      c0_valid_q   <= (tag_out == T_C0);
      c1_valid_q   <= (tag_out == T_C1);
      if (tag_out == T_DISP) begin
        disp_rgb_q <= bus.rom_rgb;
      end
      if (tag_out == T_C0) begin
        c0_rgb_q <= bus.rom_rgb;
      end
      if (tag_out == T_C1) begin
        c1_rgb_q <= bus.rom_rgb;
      end
    end
  end

`ifdef MAP_ARB_STARVE_EN
  // Wait counters saturate; the miss bit follows the tag pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w0_q        <= '0;
      w1_q        <= '0;
      miss_q      <= '0;
      disp_miss_q <= 1'b0;
    end else begin
      if (win == T_C0) begin
        w0_q <= '0;
      end else if (c0_e && w0_q != WW'(MAX_WAIT)) begin
        w0_q <= w0_q + 1'b1;
      end
      if (win == T_C1) begin
        w1_q <= '0;
      end else if (c1_e && w1_q != WW'(MAX_WAIT)) begin
        w1_q <= w1_q + 1'b1;
      end
      miss_q      <= {miss_q[ROM_LAT-1:0], ovr & bus.disp_req};
      disp_miss_q <= miss_q[ROM_LAT];
    end
  end

  assign bus.disp_miss = disp_miss_q;
`else
  assign bus.disp_miss = 1'b0;
`endif

  assign bus.rom_addr   = rom_addr_q;
  assign bus.c0_gnt     = c0_gnt_q;
  assign bus.c1_gnt     = c1_gnt_q;
  assign bus.disp_rgb   = disp_rgb_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.c0_rgb     = c0_rgb_q;
  assign bus.c0_valid   = c0_valid_q;
  assign bus.c1_rgb     = c1_rgb_q;
  assign bus.c1_valid   = c1_valid_q;

endmodule

// File: tb/tb_map_rom_arbiter.sv
// Bench for map_rom_arbiter: vector table plus scoreboard queues.
// Build with MAP_ARB_STARVE_EN to also exercise the starvation override.
`timescale 1ns/1ps
module tb_map_rom_arbiter;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 12;
  localparam int ROM_LAT = 1;
  localparam int LAT     = ROM_LAT + 2;
`ifdef MAP_ARB_STARVE_EN
  localparam int MAX_WAIT = 16;
  localparam int BURST    = 10;
`else
  localparam int MAX_WAIT = 1023;
  localparam int BURST    = 100;
`endif

  localparam logic [1:0] W_NONE = 2'd0;
  localparam logic [1:0] W_DISP = 2'd1;
  localparam logic [1:0] W_C0   = 2'd2;
  localparam logic [1:0] W_C1   = 2'd3;

  typedef struct {
    logic        d;
    logic        r0;
    logic        r1;
    logic [15:0] da;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [1:0]  win;
    logic        miss;
  } vec_t;

  typedef struct {
    int          due;
    logic [1:0]  win;
    logic        miss;
    logic [15:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  map_rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  map_rom_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .ROM_LAT (ROM_LAT),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ROM model: one-cycle latency, data = addr[11:0]
  always @(posedge clk) bus.rom_rgb <= bus.rom_addr[DATA_W-1:0];

  vec_t        vt[$];
  exp_t        gq[$];
  exp_t        vq[$];
  int          cyc;
  int          n_vec;
  int          n_bad;
  logic [15:0] e_addr;
  logic [11:0] e_drgb;
  logic [11:0] e_c0rgb;
  logic [11:0] e_c1rgb;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic check_zero();
    chk("rst_rom_addr", 32'(bus.rom_addr), 0);
    chk("rst_c0_gnt", 32'(bus.c0_gnt), 0);
    chk("rst_c1_gnt", 32'(bus.c1_gnt), 0);
    chk("rst_disp_valid", 32'(bus.disp_valid), 0);
    chk("rst_disp_miss", 32'(bus.disp_miss), 0);
    chk("rst_c0_valid", 32'(bus.c0_valid), 0);
    chk("rst_c1_valid", 32'(bus.c1_valid), 0);
    chk("rst_disp_rgb", 32'(bus.disp_rgb), 0);
    chk("rst_c0_rgb", 32'(bus.c0_rgb), 0);
    chk("rst_c1_rgb", 32'(bus.c1_rgb), 0);
  endtask

  task automatic check_cycle();
    exp_t       e;
    logic [1:0] gw;
    logic [1:0] vw;
    logic       vm;
    gw = W_NONE;
    vw = W_NONE;
    vm = 1'b0;
    if (gq.size() != 0 && gq[0].due == cyc) begin
      e      = gq.pop_front();
      gw     = e.win;
      e_addr = e.addr;
    end
    if (vq.size() != 0 && vq[0].due == cyc) begin
      e  = vq.pop_front();
      vw = e.win;
      vm = e.miss;
      if (vw == W_DISP) e_drgb = e.addr[11:0];
      if (vw == W_C0) e_c0rgb = e.addr[11:0];
      if (vw == W_C1) e_c1rgb = e.addr[11:0];
    end
    chk("c0_gnt", 32'(bus.c0_gnt), 32'(gw == W_C0));
    chk("c1_gnt", 32'(bus.c1_gnt), 32'(gw == W_C1));
    chk("rom_addr", 32'(bus.rom_addr), 32'(e_addr));
    chk("disp_valid", 32'(bus.disp_valid), 32'(vw == W_DISP));
    chk("disp_miss", 32'(bus.disp_miss), 32'(vm));
    chk("c0_valid", 32'(bus.c0_valid), 32'(vw == W_C0));
    chk("c1_valid", 32'(bus.c1_valid), 32'(vw == W_C1));
    chk("disp_rgb", 32'(bus.disp_rgb), 32'(e_drgb));
    chk("c0_rgb", 32'(bus.c0_rgb), 32'(e_c0rgb));
    chk("c1_rgb", 32'(bus.c1_rgb), 32'(e_c1rgb));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic clear_sb();
    gq.delete();
    vq.delete();
    e_addr  = '0;
    e_drgb  = '0;
    e_c0rgb = '0;
    e_c1rgb = '0;
  endtask

  task automatic do_reset(int n);
    rst = 1'b0;
    clear_sb();
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      check_zero();
    end
    bus.disp_req = 1'b0;
    bus.c0_req   = 1'b0;
    bus.c1_req   = 1'b0;
    rst = 1'b1;
  endtask

  task automatic apply(vec_t v);
    exp_t e;
    bus.disp_req  = v.d;
    bus.disp_addr = v.da;
    bus.c0_req    = v.r0;
    bus.c0_addr   = v.a0;
    bus.c1_req    = v.r1;
    bus.c1_addr   = v.a1;
    if (v.win != W_NONE) begin
      e.win  = v.win;
      e.miss = v.miss;
      e.addr = (v.win == W_DISP) ? v.da : (v.win == W_C0) ? v.a0 : v.a1;
      e.due  = cyc + 1;
      gq.push_back(e);
      e.due  = cyc + LAT;
      vq.push_back(e);
    end
    step();
  endtask

  function automatic vec_t mk(logic d, logic r0, logic r1,
                              logic [15:0] da, logic [15:0] a0,
                              logic [15:0] a1, logic [1:0] win,
                              logic miss);
    vec_t v;
    v.d    = d;
    v.r0   = r0;
    v.r1   = r1;
    v.da   = da;
    v.a0   = a0;
    v.a1   = a1;
    v.win  = win;
    v.miss = miss;
    return v;
  endfunction

  task automatic run_table();
    foreach (vt[i]) apply(vt[i]);
    vt.delete();
  endtask

  task automatic idles(int n);
    repeat (n) vt.push_back(mk(0, 0, 0, 16'h0, 16'h0, 16'h0, W_NONE, 0));
  endtask

  initial begin
    cyc           = 0;
    n_vec         = 0;
    n_bad         = 0;
    bus.disp_req  = 1'b1;
    bus.c0_req    = 1'b1;
    bus.c1_req    = 1'b1;
    bus.disp_addr = 16'h1111;
    bus.c0_addr   = 16'h2222;
    bus.c1_addr   = 16'h3333;
    do_reset(5);

    // lone probes, display burst over c0, display beating c1
    idles(2);
    vt.push_back(mk(0, 1, 0, 16'h0, 16'h1234, 16'h0, W_C0, 0));
    idles(3);
    vt.push_back(mk(0, 0, 1, 16'h0, 16'h0, 16'h5678, W_C1, 0));
    idles(3);
    for (int i = 0; i < BURST; i++) begin
      vt.push_back(mk(1, 1, 0, 16'($urandom), 16'h0ABC, 16'h0, W_DISP, 0));
    end
    vt.push_back(mk(0, 1, 0, 16'h0, 16'h0ABC, 16'h0, W_C0, 0));
    idles(4);
    for (int i = 0; i < 3; i++) begin
      vt.push_back(mk(1, 0, 1, 16'($urandom), 16'h0, 16'h0777, W_DISP, 0));
    end
    vt.push_back(mk(0, 0, 1, 16'h0, 16'h0, 16'h0777, W_C1, 0));
    idles(4);
    run_table();

    // round-robin from a fresh reset starts with c0
    do_reset(3);
    for (int i = 0; i < 8; i++) begin
      vt.push_back(mk(0, 1, 1, 16'h0, 16'h0111, 16'h0222,
                      (i % 2 == 0) ? W_C0 : W_C1, 0));
    end
    idles(4);
    run_table();

    // reset one cycle after c1_gnt: that read must never return
    apply(mk(0, 0, 1, 16'h0, 16'h0, 16'h0ABC, W_C1, 0));
    apply(mk(0, 0, 0, 16'h0, 16'h0, 16'h0ABC, W_NONE, 0));
    rst = 1'b0;
    #1;
    clear_sb();
    check_zero();
    do_reset(2);
    idles(6);
    vt.push_back(mk(0, 0, 1, 16'h0, 16'h0, 16'h0DEF, W_C1, 0));
    idles(4);
    run_table();

`ifdef MAP_ARB_STARVE_EN
    do_reset(3);
    for (int i = 0; i < MAX_WAIT; i++) begin
      vt.push_back(mk(1, 1, 0, 16'($urandom), 16'h0F0F, 16'h0, W_DISP, 0));
    end
    vt.push_back(mk(1, 1, 0, 16'($urandom), 16'h0F0F, 16'h0, W_C0, 1));
    for (int i = 0; i < 4; i++) begin
      vt.push_back(mk(1, 0, 0, 16'($urandom), 16'h0F0F, 16'h0, W_DISP, 0));
    end
    idles(4);
    run_table();
`endif

    repeat (4) step();
    chk("sb_drained", 32'(gq.size() + vq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
